// File: rtl/acc_buffer.sv
// acc_buffer: ping-pong accumulation buffer feeding the PPU.
// Two banks of AD rows x VL lanes. Partial-sum rows arrive over kt_r K tiles
// and accumulate with signed saturation. A full bank is drained as one
// o_ppu_start pulse followed by AD beats, while the other bank keeps filling.
// Ports:
//   i_clk, i_rst                      clock, async active-high reset
//   i_psum_valid/o_psum_ready         row handshake, i_psum_data (VL*PSUM_W)
//   i_k_tiles                         K tiles per output tile, latched per bank
//   i_drain_en                        permits a new PPU pass
//   o_ppu_start, o_acc_data (VL*ACC_W), o_tile_done   PPU stream
//   o_overflow (sticky), o_busy

// One lane: store (first K tile) or saturating accumulate.
module acc_lane #(
  parameter int PSUM_W = 24,
  parameter int ACC_W  = 32
) (
  input  logic [ACC_W-1:0]  acc,
  input  logic [PSUM_W-1:0] psum,
  input  logic              first,
  output logic [ACC_W-1:0]  sum,
  output logic              sat
);
  logic [ACC_W:0] ext_p, ext_a, raw;

  always_comb begin
    ext_p = {{(ACC_W+1-PSUM_W){psum[PSUM_W-1]}}, psum};
    ext_a = first ? '0 : {acc[ACC_W-1], acc};
    raw   = ext_a + ext_p;
    // one guard bit: disagreement with the sign bit means the sum left range
    sat   = raw[ACC_W] != raw[ACC_W-1];
    if (sat) sum = raw[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    else     sum = raw[ACC_W-1:0];
  end
endmodule

module acc_buffer #(
  parameter int VL     = 16,
  parameter int AD     = 16,
  parameter int PSUM_W = 24,
  parameter int ACC_W  = 32,
  parameter int KT_W   = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_psum_valid,
  output logic                  o_psum_ready,
  input  logic [VL*PSUM_W-1:0]  i_psum_data,
  input  logic [KT_W-1:0]       i_k_tiles,
  input  logic                  i_drain_en,
  output logic                  o_ppu_start,
  output logic [VL*ACC_W-1:0]   o_acc_data,
  output logic                  o_tile_done,
  output logic                  o_overflow,
  output logic                  o_busy
);
  localparam int RW = (AD > 1) ? $clog2(AD) : 1;

  typedef enum logic [1:0] {EMPTY, FILL, FULL, DRAIN} bank_st_e;
  typedef enum logic [1:0] {D_IDLE, D_START, D_BEAT} drain_st_e;
  typedef logic [VL-1:0][ACC_W-1:0] row_t;

  row_t       mem [2][AD];
  bank_st_e   bst [2];
  logic       wr_bank, rd_bank;
  logic [RW-1:0]   wr_row, rd_row;
  logic [KT_W-1:0] k_cnt, kt_r, kt_in, kt_cur;
  drain_st_e  dst, dst_nx;
  logic       hs, first_hs, last_wr, drain_go, drain_last;
  row_t       cur_row, new_row;
  logic [VL-1:0] lane_sat;

  assign o_psum_ready = (bst[wr_bank] == EMPTY) || (bst[wr_bank] == FILL);
  assign hs       = i_psum_valid && o_psum_ready;
  assign first_hs = hs && (bst[wr_bank] == EMPTY);
  assign kt_in    = (i_k_tiles == '0) ? KT_W'(1) : i_k_tiles;
  // on the first row kt_r is not loaded yet, so use the incoming count
  assign kt_cur   = (bst[wr_bank] == EMPTY) ? kt_in : kt_r;
  assign last_wr  = hs && (wr_row == RW'(AD-1)) && (k_cnt == kt_cur - 1'b1);
  assign cur_row  = mem[wr_bank][wr_row];
  assign o_busy   = (bst[0] != EMPTY) || (bst[1] != EMPTY) || (dst != D_IDLE);

  for (genvar g = 0; g < VL; g++) begin : g_lane
    acc_lane #(.PSUM_W(PSUM_W), .ACC_W(ACC_W)) u_lane (
      .acc   (cur_row[g]),
      .psum  (i_psum_data[g*PSUM_W +: PSUM_W]),
      .first (k_cnt == '0),
      .sum   (new_row[g]),
      .sat   (lane_sat[g])
    );
  end

  // bank storage: no reset, contents are always rewritten at k_cnt==0
  always_ff @(posedge i_clk) begin
    if (hs) mem[wr_bank][wr_row] <= new_row;
  end

  always_comb begin
    dst_nx     = dst;
    drain_go   = 1'b0;
    drain_last = 1'b0;
    o_ppu_start = 1'b0;
    o_acc_data  = '0;
    case (dst)
      D_IDLE:  if (bst[rd_bank] == FULL && i_drain_en) begin
                 dst_nx   = D_START;
                 drain_go = 1'b1;
               end
      D_START: begin
                 o_ppu_start = 1'b1;
                 dst_nx      = D_BEAT;
               end
      D_BEAT:  begin
                 o_acc_data = mem[rd_bank][rd_row];
                 if (rd_row == RW'(AD-1)) begin
                   dst_nx     = D_IDLE;
                   drain_last = 1'b1;
                 end
               end
      default: dst_nx = D_IDLE;
    endcase
    o_tile_done = drain_last;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      bst[0]     <= EMPTY;
      bst[1]     <= EMPTY;
      wr_bank    <= 1'b0;
      rd_bank    <= 1'b0;
      wr_row     <= '0;
      rd_row     <= '0;
      k_cnt      <= '0;
      kt_r       <= '0;
      dst        <= D_IDLE;
      o_overflow <= 1'b0;
    end else begin
      dst <= dst_nx;
      if (hs) begin
        if (first_hs)  kt_r <= kt_in;
        if (|lane_sat) o_overflow <= 1'b1;
        if (last_wr) begin
          bst[wr_bank] <= FULL;
          wr_row       <= '0;
          k_cnt        <= '0;
          wr_bank      <= ~wr_bank;
        end else begin
          if (first_hs) bst[wr_bank] <= FILL;
          if (wr_row == RW'(AD-1)) begin
            wr_row <= '0;
            k_cnt  <= k_cnt + 1'b1;
          end else begin
            wr_row <= wr_row + 1'b1;
          end
        end
      end
      // the fill side only touches EMPTY/FILL banks, the drain side only
      // FULL/DRAIN ones, so these never target the same bank in one cycle
      if (drain_go) bst[rd_bank] <= DRAIN;
      if (dst == D_START)     rd_row <= '0;
      else if (dst == D_BEAT) rd_row <= rd_row + 1'b1;
      if (drain_last) begin
        bst[rd_bank] <= EMPTY;
        rd_bank      <= ~rd_bank;
      end
    end
  end
endmodule

// File: tb/tb_acc_buffer.sv
module tb_acc_buffer;
  localparam int VL = 16, AD = 16, PSUM_W = 24, ACC_W = 26, KT_W = 8;
  typedef logic [VL*PSUM_W-1:0] psum_t;
  typedef logic [VL*ACC_W-1:0]  row_t;
  typedef struct {
    int kt; int v0; int vo; bit idx; int exp0; int expo; bit ovf;
  } vec_t;

  logic i_clk = 0, i_rst = 1, i_psum_valid = 0, i_drain_en = 0;
  psum_t i_psum_data = '0;
  logic [KT_W-1:0] i_k_tiles = '0;
  logic o_psum_ready, o_ppu_start, o_tile_done, o_overflow, o_busy;
  row_t o_acc_data;

  acc_buffer #(.VL(VL), .AD(AD), .PSUM_W(PSUM_W), .ACC_W(ACC_W), .KT_W(KT_W)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_psum_valid(i_psum_valid), .o_psum_ready(o_psum_ready),
    .i_psum_data(i_psum_data), .i_k_tiles(i_k_tiles), .i_drain_en(i_drain_en),
    .o_ppu_start(o_ppu_start), .o_acc_data(o_acc_data), .o_tile_done(o_tile_done),
    .o_overflow(o_overflow), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  int errs = 0, checks = 0, stalls = 0, start_cnt = 0;
  int mbeat = -1, last_start = -1000, done_cyc = -1;
  row_t exp_rows[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic psum_t make_psum(int v0, int vo, bit idx, int r);
    psum_t p;
    for (int g = 0; g < VL; g++)
      p[g*PSUM_W +: PSUM_W] = PSUM_W'(((g == 0) ? v0 : vo) + (idx ? r*16 + g : 0));
    return p;
  endfunction

  function automatic row_t make_exp(int e0, int eo, bit idx, int r);
    row_t x;
    for (int g = 0; g < VL; g++)
      x[g*ACC_W +: ACC_W] = ACC_W'(((g == 0) ? e0 : eo) + (idx ? r*16 + g : 0));
    return x;
  endfunction

  task automatic push_tile(int e0, int eo, bit idx);
    for (int r = 0; r < AD; r++) exp_rows.push_back(make_exp(e0, eo, idx, r));
  endtask

  // called aligned at posedge+#1; leaves i_psum_valid high for back-to-back rows
  task automatic send_row(input psum_t d, input int kt);
    int n = 0;
    i_psum_valid = 1; i_psum_data = d; i_k_tiles = KT_W'(kt);
    while (!o_psum_ready && n < 500) begin
      @(posedge i_clk); #1; n++; stalls++;
    end
    if (n >= 500) chk("send_timeout", 1, 0);
    @(posedge i_clk); #1;
  endtask

  task automatic send_tile(int kt, int v0, int vo, bit idx);
    int nk = (kt == 0) ? 1 : kt;
    for (int k = 0; k < nk; k++)
      for (int r = 0; r < AD; r++) send_row(make_psum(v0, vo, idx, r), kt);
    i_psum_valid = 0;
  endtask

  task automatic wait_drain(input string nm);
    int n = 0;
    while ((exp_rows.size() != 0 || o_busy) && n < 400) begin
      @(posedge i_clk); #1; n++;
    end
    chk({nm, "_drain_timeout"}, n >= 400, 0);
    chk({nm, "_busy_fall"}, cyc, done_cyc + 1);
  endtask

  // drain monitor / scoreboard, sampled on the falling edge
  always @(negedge i_clk) begin
    if (i_rst) begin
      if (mbeat >= 0)
        for (int i = mbeat; i < AD; i++) if (exp_rows.size() > 0) void'(exp_rows.pop_front());
      mbeat = -1;
      last_start = -1000;
      chk("reset_outputs", {o_ppu_start, o_tile_done, o_overflow, o_busy, o_psum_ready, |o_acc_data},
          6'b000010);
    end else if (mbeat >= 0) begin
      chk("start_during_beat", o_ppu_start, 0);
      checks++;
      if (exp_rows.size() == 0) begin
        errs++;
        $display("FAIL beat%0d: no expected row", mbeat);
      end else begin
        if (o_acc_data !== exp_rows[0]) begin
          errs++;
          $display("FAIL beat%0d data: got %h want %h", mbeat, o_acc_data, exp_rows[0]);
        end
        void'(exp_rows.pop_front());
      end
      chk("tile_done", o_tile_done, mbeat == AD-1);
      if (mbeat == AD-1) begin
        done_cyc = cyc;
        mbeat = -1;
      end else mbeat++;
    end else begin
      chk("idle_data_zero", |o_acc_data, 0);
      chk("idle_tile_done", o_tile_done, 0);
      if (o_ppu_start) begin
        chk("start_expected", exp_rows.size() >= AD, 1);
        chk("start_spacing_ok", (cyc - last_start) >= AD + 1, 1);
        start_cnt++;
        last_start = cyc;
        mbeat = 0;
      end
    end
  end

  vec_t vecs[6];
  int s0, n;

  initial begin
    vecs[0] = '{kt:1, v0:0,         vo:0,    idx:1, exp0:0,         expo:0,    ovf:0};
    vecs[1] = '{kt:3, v0:-5,        vo:-5,   idx:0, exp0:-15,       expo:-15,  ovf:0};
    vecs[2] = '{kt:0, v0:7,         vo:-3,   idx:0, exp0:7,         expo:-3,   ovf:0};
    vecs[3] = '{kt:2, v0:100,       vo:-100, idx:0, exp0:200,       expo:-200, ovf:0};
    vecs[4] = '{kt:5, v0:-8388608,  vo:1,    idx:0, exp0:-33554432, expo:5,    ovf:1};
    vecs[5] = '{kt:5, v0:8388607,   vo:0,    idx:0, exp0:33554431,  expo:0,    ovf:1};

    repeat (3) @(posedge i_clk);
    #1 i_rst = 0;
    chk("post_reset_ready", o_psum_ready, 1);
    chk("post_reset_busy", o_busy, 0);

    // table-driven single-tile runs
    i_drain_en = 1;
    for (int i = 0; i < 6; i++) begin
      s0 = start_cnt;
      push_tile(vecs[i].exp0, vecs[i].expo, vecs[i].idx);
      send_tile(vecs[i].kt, vecs[i].v0, vecs[i].vo, vecs[i].idx);
      wait_drain($sformatf("vec%0d", i));
      chk($sformatf("vec%0d_starts", i), start_cnt - s0, 1);
      chk($sformatf("vec%0d_overflow", i), o_overflow, vecs[i].ovf);
    end

    // ping-pong: three tiles with valid held high
    s0 = start_cnt;
    stalls = 0;
    for (int t = 0; t < 3; t++) push_tile(1000*(t+1), 1000*(t+1), 1);
    for (int t = 0; t < 3; t++)
      for (int r = 0; r < AD; r++) send_row(make_psum(1000*(t+1), 1000*(t+1), 1, r), 1);
    i_psum_valid = 0;
    chk("pp_stall_cycles", stalls, 2);
    wait_drain("pp");
    chk("pp_starts", start_cnt - s0, 3);

    // backpressure: both banks full with drain disabled
    i_drain_en = 0;
    s0 = start_cnt;
    send_tile(1, 256, 256, 1);
    send_tile(1, 512, 512, 1);
    chk("bp_ready_low", o_psum_ready, 0);
    repeat (20) @(posedge i_clk);
    #1 chk("bp_no_start", start_cnt - s0, 0);
    chk("bp_ready_still_low", o_psum_ready, 0);
    push_tile(256, 256, 1);
    push_tile(512, 512, 1);
    i_drain_en = 1;
    n = 0;
    while (start_cnt == s0 && n < 50) begin @(posedge i_clk); #1; n++; end
    repeat (2) @(posedge i_clk);
    #1 i_drain_en = 0;
    n = 0;
    while (exp_rows.size() > AD && n < 100) begin @(posedge i_clk); #1; n++; end
    repeat (3) @(posedge i_clk);
    #1 chk("bp_first_pass_only", start_cnt - s0, 1);
    chk("bp_ready_after_pass", o_psum_ready, 1);
    chk("bp_busy_holding", o_busy, 1);
    i_drain_en = 1;
    wait_drain("bp");
    chk("bp_starts", start_cnt - s0, 2);

    // reset in the middle of a drain
    push_tile(768, 768, 1);
    send_tile(1, 768, 768, 1);
    n = 0;
    while (mbeat != 8 && n < 200) begin @(negedge i_clk); #1; n++; end
    chk("rst_reach_beat", n < 200, 1);
    i_rst = 1;
    #1 chk("rst_async_outputs", {o_ppu_start, o_tile_done, o_overflow, o_busy, o_psum_ready, |o_acc_data},
           6'b000010);
    repeat (2) @(posedge i_clk);
    #1 i_rst = 0;
    chk("rst_ready", o_psum_ready, 1);
    chk("rst_busy", o_busy, 0);
    chk("rst_rows_flushed", exp_rows.size(), 0);
    s0 = start_cnt;
    push_tile(1024, 1024, 1);
    send_tile(1, 1024, 1024, 1);
    wait_drain("rst_fresh");
    chk("rst_fresh_starts", start_cnt - s0, 1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
